fifo_rd_ctrl: RTL and testbench
===============================

Name: fifo_rd_ctrl

Overview:
Read-side controller for the dual-clock asynchronous FIFO, running entirely in the read clock domain.
- Synchronizes the Gray-coded write pointer and keeps the read pointer.
- Computes the empty, almost-empty and occupancy flags.
- Drives the read port of the FIFO memory and absorbs its 1-cycle read latency.
- Presents data to the consumer as first-word-fall-through with a valid/ready handshake.
- Its Gray read pointer returns to the write-side controller.

Parameters:
DATA_SIZE, 32, data word width
MEM_SIZE, 32, memory depth in words; must equal 2**(ADDR_LEN-1)
ADDR_LEN, 6, pointer width including wrap bit; memory address is ADDR_LEN-1 bits
AEMPTY_THRESH, 4, almost_empty asserts when rd_count <= this value

Ports:
rclk  in  1  read-domain clock (the only clock)
resetn  in  1  asynchronous active-low reset
wptr_gray  in  ADDR_LEN  Gray write pointer from the write domain, asynchronous to rclk
ram_r_en  out  1  memory read enable
ram_r_addr  out  ADDR_LEN-1  memory read address
ram_r_data  in  DATA_SIZE  memory read data, registered, valid the cycle after ram_r_en
ram_r_valid  in  1  memory read-valid strobe, ram_r_en delayed one cycle
rptr_gray  out  ADDR_LEN  registered Gray read pointer to the write domain
m_data  out  DATA_SIZE  consumer data, head of the output buffer
m_valid  out  1  m_data holds a word
m_ready  in  1  consumer accepts the word
empty  out  1  no unread words remain in memory (memory side)
almost_empty  out  1  rd_count <= AEMPTY_THRESH
rd_count  out  ADDR_LEN  words in memory not yet fetched

Behaviour:
- Reset (async, resetn=0): clears rbin, rptr_gray, both sync stages, the output buffer, m_data and the in-flight flag.
  - Resulting outputs: m_valid=0, m_data=0, rptr_gray=0, rd_count=0, empty=1, almost_empty=1, ram_r_en=0.
  - A read in flight at reset is discarded; ram_r_valid is ignored while resetn=0.
- Write-pointer synchronization: 2-flop synchronizer on wptr_gray gives wq2. wbin = gray2bin(wq2), combinational.
- Read pointer: rbin is ADDR_LEN-bit binary and increments by 1 on each rclk edge where ram_r_en=1.
  - rptr_gray <= bin2gray(rbin_next), registered on the same edge.
  - Wraps modulo 2**ADDR_LEN; ram_r_addr = rbin[ADDR_LEN-2:0].
- empty = (bin2gray(rbin) == wq2). Full detection belongs to the write side and is not produced here.
- rd_count = wbin - rbin, modulo 2**ADDR_LEN. Range 0..MEM_SIZE.
- Output buffer: 2-entry register FIFO (out_cnt 0..2); the in-flight flag is 0/1.
  - pop = m_valid & m_ready.
  - ram_r_en = !empty & ((out_cnt + inflight - pop) < 2), combinational.
  - inflight <= ram_r_en.
  - On ram_r_valid=1, ram_r_data is pushed into the buffer. Push and pop in the same cycle leave out_cnt unchanged.
- Handshake:
  - m_valid = (out_cnt != 0); m_data = head entry.
  - While m_valid=1 and m_ready=0, m_data and m_valid hold stable.
  - The buffer never overflows: the credit rule guarantees this, and a bench assertion checks it.
- Throughput: 1 word/cycle sustained when m_ready=1 and memory is non-empty.
- Latency:
  - wptr_gray changes before edge N.
  - wq2 updates at N+1, so empty falls after N+1.
  - ram_r_en is high in the cycle ending at N+2; memory data is registered at N+2.
  - The word is captured into the output buffer at N+3; m_valid=1 after N+3.
- The last word drains: empty=1 while m_valid=1 is legal. No fetches are issued while empty=1.

Decomposition:
- Package fifo_pkg: bin2gray and gray2bin functions parameterized on width; the shared ADDR_LEN/DATA_SIZE defaults.
- One sub-module, sync_2ff: an N-bit 2-flop synchronizer with asynchronous active-low reset to 0, reused by the write-side controller for rptr_gray.

Test Plan:
- Reset with resetn=0 for 3 cycles, then release -> m_valid=0, empty=1, almost_empty=1, rd_count=0, rptr_gray=0, ram_r_en never asserted.
- Single word: set wptr_gray=bin2gray(1) after the edge N-1 -> empty=0 after N+1, ram_r_en with ram_r_addr=0 in cycle N+2, m_valid=1 with the model value after N+3, rptr_gray=0b000001 after N+2.
- Burst of 8, m_ready tied 1 -> 8 consecutive m_valid cycles, data in order, rptr_gray=bin2gray(8), empty=1 afterwards.
- Backpressure: 8 words, m_ready=0 for 10 cycles -> ram_r_en stops after 2 fetches, m_data stable, rd_count=6; release m_ready -> all 8 words in order, none lost or duplicated.
- Wrap-around: push 40 words total in bursts of 20 (ADDR_LEN=6) -> ram_r_addr wraps 31->0, rbin crosses 32, ordering intact, rd_count and almost_empty correct at each step (almost_empty=1 exactly when rd_count<=4).
- Reset mid-burst, with a read in flight and out_cnt=2 -> all outputs return to reset values immediately; the late ram_r_valid is ignored.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared pointer helpers and default widths for the dual-clock FIFO controllers.
// Pointer functions work on a 32-bit container; callers cast to their width.
package fifo_pkg;

    localparam int ADDR_LEN_DEF  = 6;
    localparam int DATA_SIZE_DEF = 32;
    localparam int PTR_W_MAX     = 32;

    typedef logic [PTR_W_MAX-1:0] ptr_t;

    function automatic ptr_t bin2gray(input ptr_t b);
        return b ^ (b >> 1);
    endfunction

    // Upper bits of a zero-extended input stay zero, so any width <= 32 works.
    function automatic ptr_t gray2bin(input ptr_t g);
        ptr_t b;
        b[PTR_W_MAX-1] = g[PTR_W_MAX-1];
        for (int i = PTR_W_MAX-2; i >= 0; i--)
            b[i] = b[i+1] ^ g[i];
        return b;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// N-bit two-flop synchronizer for Gray pointers crossing clock domains.
module sync_2ff #(
    parameter int W = 6
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic [W-1:0] i_d,
    output logic [W-1:0] o_q
);

    logic [W-1:0] r_meta;
    logic [W-1:0] r_sync;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_meta <= '0;
            r_sync <= '0;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/fifo_rd_ctrl.sv
// Read-side controller of the async FIFO: pointer sync, flags, memory read port
// and a 2-entry first-word-fall-through output buffer with valid/ready.
module fifo_rd_ctrl
    import fifo_pkg::*;
#(
    parameter int DATA_SIZE     = DATA_SIZE_DEF,
    parameter int MEM_SIZE      = 32,
    parameter int ADDR_LEN      = ADDR_LEN_DEF,
    parameter int AEMPTY_THRESH = 4
) (
    input  logic                 rclk,
    input  logic                 resetn,
    input  logic [ADDR_LEN-1:0]  wptr_gray,
    output logic                 ram_r_en,
    output logic [ADDR_LEN-2:0]  ram_r_addr,
    input  logic [DATA_SIZE-1:0] ram_r_data,
    input  logic                 ram_r_valid,
    output logic [ADDR_LEN-1:0]  rptr_gray,
    output logic [DATA_SIZE-1:0] m_data,
    output logic                 m_valid,
    input  logic                 m_ready,
    output logic                 empty,
    output logic                 almost_empty,
    output logic [ADDR_LEN-1:0]  rd_count
);

    localparam logic [ADDR_LEN-1:0] AE_TH = ADDR_LEN'(AEMPTY_THRESH);
    localparam int                  MAW   = $clog2(MEM_SIZE);

    logic [ADDR_LEN-1:0]  w_wq2;
    logic [ADDR_LEN-1:0]  w_wbin;
    logic [ADDR_LEN-1:0]  w_rbin_next;
    logic [ADDR_LEN-1:0]  r_rbin;
    logic [ADDR_LEN-1:0]  r_rptr_gray;
    logic                 w_pop;
    logic                 w_push;
    logic [2:0]           w_credit;
    logic [1:0]           r_out_cnt;
    logic                 r_inflight;
    logic [DATA_SIZE-1:0] r_buf0;
    logic [DATA_SIZE-1:0] r_buf1;

    sync_2ff #(.W(ADDR_LEN)) u_wptr_sync (
        .i_clk   (rclk),
        .i_rst_n (resetn),
        .i_d     (wptr_gray),
        .o_q     (w_wq2)
    );

    assign w_wbin       = ADDR_LEN'(gray2bin(ptr_t'(w_wq2)));
    assign empty        = (ADDR_LEN'(bin2gray(ptr_t'(r_rbin))) == w_wq2);
    assign rd_count     = w_wbin - r_rbin;
    assign almost_empty = (rd_count <= AE_TH);

    // Credit counts buffered words plus the one in flight, so a fetch is only
    // issued when a slot is guaranteed on arrival; the buffer cannot overflow.
    assign w_pop    = (r_out_cnt != 2'd0) & m_ready;
    assign w_credit = {1'b0, r_out_cnt} + {2'b00, r_inflight} - {2'b00, w_pop};
    assign ram_r_en = !empty & (w_credit < 3'd2);

    assign w_rbin_next = r_rbin + {{(ADDR_LEN-1){1'b0}}, ram_r_en};
    assign ram_r_addr  = r_rbin[MAW-1:0];
    assign rptr_gray   = r_rptr_gray;

    always_ff @(posedge rclk or negedge resetn) begin
        if (!resetn) begin
            r_rbin      <= '0;
            r_rptr_gray <= '0;
            r_inflight  <= 1'b0;
        end else begin
            r_rbin      <= w_rbin_next;
            r_rptr_gray <= ADDR_LEN'(bin2gray(ptr_t'(w_rbin_next)));
            r_inflight  <= ram_r_en;
        end
    end

    // Gating with the in-flight flag drops a stale strobe from a read issued
    // before a reset.
    assign w_push = ram_r_valid & r_inflight;

    always_ff @(posedge rclk or negedge resetn) begin
        if (!resetn) begin
            r_out_cnt <= 2'd0;
            r_buf0    <= '0;
            r_buf1    <= '0;
        end else begin
            case ({w_push, w_pop})
                2'b10: begin
                    if (r_out_cnt == 2'd0) r_buf0 <= ram_r_data;
                    else                   r_buf1 <= ram_r_data;
                    r_out_cnt <= r_out_cnt + 2'd1;
                end
                2'b01: begin
                    r_buf0    <= r_buf1;
                    r_out_cnt <= r_out_cnt - 2'd1;
                end
                2'b11: begin
                    if (r_out_cnt == 2'd1) begin
                        r_buf0 <= ram_r_data;
                    end else begin
                        r_buf0 <= r_buf1;
                        r_buf1 <= ram_r_data;
                    end
                end
                default: ;
            endcase
        end
    end

    assign m_valid = (r_out_cnt != 2'd0);
    assign m_data  = r_buf0;

endmodule

// File: tb/tb_fifo_rd_ctrl.sv
// Directed bench for fifo_rd_ctrl: phase table plus hand-written corner sequences,
// with a memory model and an in-order scoreboard on the consumer side.
module tb_fifo_rd_ctrl;

    localparam int AL = 6;
    localparam int DW = 32;

    logic          rclk = 1'b0;
    logic          resetn = 1'b0;
    logic [AL-1:0] wptr_gray = '0;
    logic          ram_r_en;
    logic [AL-2:0] ram_r_addr;
    logic [DW-1:0] ram_r_data = '0;
    logic          ram_r_valid = 1'b0;
    logic [AL-1:0] rptr_gray;
    logic [DW-1:0] m_data;
    logic          m_valid;
    logic          m_ready = 1'b0;
    logic          empty;
    logic          almost_empty;
    logic [AL-1:0] rd_count;

    always #5 rclk = ~rclk;

    fifo_rd_ctrl #(.DATA_SIZE(DW), .MEM_SIZE(32), .ADDR_LEN(AL), .AEMPTY_THRESH(4)) dut (
        .rclk(rclk), .resetn(resetn), .wptr_gray(wptr_gray),
        .ram_r_en(ram_r_en), .ram_r_addr(ram_r_addr), .ram_r_data(ram_r_data),
        .ram_r_valid(ram_r_valid), .rptr_gray(rptr_gray), .m_data(m_data),
        .m_valid(m_valid), .m_ready(m_ready), .empty(empty),
        .almost_empty(almost_empty), .rd_count(rd_count)
    );

    // Memory model: registered read data, valid strobe is ram_r_en delayed, not reset.
    logic [DW-1:0] mem [32];
    always @(posedge rclk) begin
        ram_r_valid <= ram_r_en;
        if (ram_r_en) ram_r_data <= mem[ram_r_addr];
    end

    int            checks = 0;
    int            failures = 0;
    logic [DW-1:0] exp_q [$];
    logic [AL-1:0] wbin = '0;
    logic [DW-1:0] next_data = 32'hA000_0000;

    function automatic logic [AL-1:0] g(input logic [AL-1:0] b);
        return b ^ (b >> 1);
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h t=%0t", nm, act, exp, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge rclk);
            #1;
        end
    endtask

    task automatic write_words(input int n);
        for (int i = 0; i < n; i++) begin
            mem[wbin[4:0]] = next_data;
            exp_q.push_back(next_data);
            next_data++;
            wbin++;
        end
        wptr_gray = g(wbin);
    endtask

    // Consumer-side monitor, sampled on the falling edge.
    logic          pv_hold = 1'b0;
    logic [DW-1:0] pv_data = '0;
    int            outst = 0;
    logic [4:0]    last_addr = '0;
    logic          saw_wrap = 1'b0;

    always @(negedge rclk) begin
        if (!resetn) begin
            pv_hold = 1'b0;
            outst   = 0;
        end else begin
            if (pv_hold) begin
                chk("hold_valid", 32'(m_valid), 32'd1);
                chk("hold_data", m_data, pv_data);
            end
            pv_hold = m_valid & !m_ready;
            pv_data = m_data;
            if (m_valid && m_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL pop_unexpected actual=%h expected=none", m_data);
                end else begin
                    chk("pop_data", m_data, exp_q.pop_front());
                end
            end
            chk("ae_vs_count", 32'(almost_empty), 32'(rd_count <= 6'd4));
            chk("empty_vs_count", 32'(empty), 32'(rd_count == 6'd0));
            if (ram_r_en) begin
                chk("fetch_when_empty", 32'(empty), 32'd0);
                if (last_addr == 5'd31 && ram_r_addr == 5'd0) saw_wrap = 1'b1;
                last_addr = ram_r_addr;
            end
            outst = outst + int'(ram_r_en) - int'(m_valid && m_ready);
            chk("buf_overflow", 32'(outst <= 2), 32'd1);
        end
    end

    typedef struct {
        int          nwr;
        logic        rdy;
        int          cyc;
        logic        mv;
        logic [31:0] md;
        logic        e;
        logic        ae;
        logic [5:0]  cnt;
        logic [5:0]  rp;
    } vec_t;

    vec_t tbl [8];

    task automatic chk_reset_outs(input string tag);
        chk({tag, "_m_valid"}, 32'(m_valid), 32'd0);
        chk({tag, "_m_data"}, m_data, 32'd0);
        chk({tag, "_rptr"}, 32'(rptr_gray), 32'd0);
        chk({tag, "_rd_count"}, 32'(rd_count), 32'd0);
        chk({tag, "_empty"}, 32'(empty), 32'd1);
        chk({tag, "_aempty"}, 32'(almost_empty), 32'd1);
        chk({tag, "_r_en"}, 32'(ram_r_en), 32'd0);
    endtask

    initial begin
        int tot, cur, run;
        //          nwr rdy cyc  mv  md            e  ae cnt rptr
        tbl[0] = '{8,  0, 10, 1, 32'hA000_0009, 0, 0, 6,  14};  // backpressure: 2 fetches only
        tbl[1] = '{0,  1, 12, 0, 32'h0,         1, 1, 0,  25};
        tbl[2] = '{20, 0, 8,  1, 32'hA000_0011, 0, 0, 18, 26};
        tbl[3] = '{0,  1, 15, 1, 32'hA000_0020, 0, 1, 3,  51};  // rbin crossed 32
        tbl[4] = '{0,  1, 5,  0, 32'h0,         1, 1, 0,  55};
        tbl[5] = '{20, 1, 3,  0, 32'h0,         0, 0, 19, 53};
        tbl[6] = '{0,  1, 17, 1, 32'hA000_0035, 0, 1, 2,  44};
        tbl[7] = '{0,  1, 10, 0, 32'h0,         1, 1, 0,  37};

        for (int i = 0; i < 3; i++) begin
            tick(1);
            chk("rst_hold_r_en", 32'(ram_r_en), 32'd0);
        end
        resetn = 1'b1;
        chk_reset_outs("reset");
        tick(2);
        chk_reset_outs("post_reset");

        // Single word: edge N sync, N+1 visible, N+2 fetch, N+3 valid.
        write_words(1);
        tick(1);
        chk("sw_n_empty", 32'(empty), 32'd1);
        chk("sw_n_r_en", 32'(ram_r_en), 32'd0);
        tick(1);
        chk("sw_n1_empty", 32'(empty), 32'd0);
        chk("sw_n1_count", 32'(rd_count), 32'd1);
        chk("sw_n1_r_en", 32'(ram_r_en), 32'd1);
        chk("sw_n1_addr", 32'(ram_r_addr), 32'd0);
        tick(1);
        chk("sw_n2_rptr", 32'(rptr_gray), 32'd1);
        chk("sw_n2_r_en", 32'(ram_r_en), 32'd0);
        chk("sw_n2_m_valid", 32'(m_valid), 32'd0);
        chk("sw_n2_empty", 32'(empty), 32'd1);
        tick(1);
        chk("sw_n3_m_valid", 32'(m_valid), 32'd1);
        chk("sw_n3_m_data", m_data, 32'hA000_0000);
        tick(3);
        chk("sw_hold_m_data", m_data, 32'hA000_0000);

        // Burst of 8 with consumer always ready.
        m_ready = 1'b1;
        tick(1);
        chk("burst_pre_m_valid", 32'(m_valid), 32'd0);
        write_words(8);
        tot = 0; cur = 0; run = 0;
        for (int i = 0; i < 14; i++) begin
            tick(1);
            if (m_valid) begin
                tot++;
                cur++;
                if (cur > run) run = cur;
            end else begin
                cur = 0;
            end
        end
        chk("burst_valid_total", 32'(tot), 32'd8);
        chk("burst_valid_run", 32'(run), 32'd8);
        chk("burst_rptr", 32'(rptr_gray), 32'(g(6'd9)));
        chk("burst_empty", 32'(empty), 32'd1);

        for (int i = 0; i < 8; i++) begin
            write_words(tbl[i].nwr);
            m_ready = tbl[i].rdy;
            tick(tbl[i].cyc);
            chk($sformatf("row%0d_m_valid", i), 32'(m_valid), 32'(tbl[i].mv));
            if (tbl[i].mv) chk($sformatf("row%0d_m_data", i), m_data, tbl[i].md);
            chk($sformatf("row%0d_empty", i), 32'(empty), 32'(tbl[i].e));
            chk($sformatf("row%0d_aempty", i), 32'(almost_empty), 32'(tbl[i].ae));
            chk($sformatf("row%0d_rd_count", i), 32'(rd_count), 32'(tbl[i].cnt));
            chk($sformatf("row%0d_rptr", i), 32'(rptr_gray), 32'(tbl[i].rp));
        end
        chk("addr_wrapped", 32'(saw_wrap), 32'd1);

        // Reset with one word buffered and a read in flight.
        m_ready = 1'b0;
        write_words(8);
        tick(4);
        chk("pre_rst_m_valid", 32'(m_valid), 32'd1);
        chk("pre_rst_m_data", m_data, 32'hA000_0039);
        resetn = 1'b0;
        wptr_gray = '0;
        wbin = '0;
        exp_q.delete();
        #1;
        chk_reset_outs("async_rst");
        for (int i = 0; i < 3; i++) begin
            tick(1);
            chk("mid_rst_m_valid", 32'(m_valid), 32'd0);
            chk("mid_rst_r_en", 32'(ram_r_en), 32'd0);
        end
        resetn = 1'b1;
        tick(2);
        chk_reset_outs("after_mid_rst");

        m_ready = 1'b1;
        write_words(2);
        tick(8);
        chk("final_empty", 32'(empty), 32'd1);
        chk("final_m_valid", 32'(m_valid), 32'd0);
        chk("final_rptr", 32'(rptr_gray), 32'(g(6'd2)));
        chk("final_all_popped", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
